// File: rtl/mul_div_iter_32.sv
// Iterative 32-bit multiply/divide unit (MULTU/MULT/DIVU/DIV), one bit per cycle.
// state | meaning: IDLE accept request, BUSY iterate cnt 0..31, DONE result valid one cycle.
module mul_div_iter_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        squashn,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        stalled,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        div_r, neg_lo, neg_hi, div0;
  logic [31:0] a_mag, b_mag, a_in, b_in;
  logic [63:0] acc, acc_step;
  logic [32:0] add_sum, rem_sh, diff;
  logic [31:0] res_hi, res_lo;
  logic        accept, last;

  assign accept = (state == IDLE) && en && squashn;
  assign last   = (state == BUSY) && (cnt == 6'd31);

  always_comb begin
    a_in = (op[0] && opA[31]) ? -opA : opA;
    b_in = (op[0] && opB[31]) ? -opB : opB;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    rem_sh  = {acc[63:32], acc[31]};
    diff    = rem_sh - {1'b0, b_mag};
    if (div_r)
      acc_step = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                          : {diff[31:0], acc[30:0], 1'b1};
    else
      acc_step = {add_sum, acc[31:1]};
  end

  // divide-by-zero leaves the dividend magnitude as remainder, so the remainder
  // sign fix reproduces the original opA
  always_comb begin
    if (!div_r) begin
      {res_hi, res_lo} = neg_lo ? -acc_step : acc_step;
    end else begin
      res_lo = div0 ? 32'hFFFF_FFFF : (neg_lo ? -acc_step[31:0] : acc_step[31:0]);
      res_hi = neg_hi ? -acc_step[63:32] : acc_step[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && squashn) state_nxt = BUSY;
      BUSY:    if (cnt == 6'd31)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!squashn) state_nxt = IDLE;
  end

  always_comb begin
    stalled = en && squashn && (state != DONE) && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 6'd0;
      div_r  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      a_mag  <= 32'd0;
      b_mag  <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (!squashn) begin
      cnt <= 6'd0;
    end else if (accept) begin
      cnt    <= 6'd0;
      div_r  <= op[1];
      neg_lo <= op[0] && (opA[31] ^ opB[31]);
      neg_hi <= op[1] && op[0] && opA[31];
      div0   <= op[1] && (opB == 32'd0);
      a_mag  <= a_in;
      b_mag  <= b_in;
      acc    <= op[1] ? {32'd0, a_in} : {32'd0, b_in};
    end else if (state == BUSY) begin
      cnt <= cnt + 6'd1;
      acc <= acc_step;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
